// File: rtl/modulo_status_decoder_pkg.sv
// Shared definitions for the status-digit code: FSM states, code words and
// the legality/decode rule used by both receive and encoder-side checkers.
package modulo_status_decoder_pkg;

  typedef enum logic [1:0] {
    NOLOCK  = 2'd0,
    CONFIRM = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam logic [3:0] CODE_S00 = 4'hC;
  localparam logic [3:0] CODE_S01 = 4'hB;
  localparam logic [3:0] CODE_S10 = 4'hA;
  localparam logic [3:0] CODE_S11 = 4'hD;

  typedef struct packed {
    logic       legal;
    logic [1:0] status;
  } code_info_t;

  // A word is legal when its top bit is set and bits 2/1 are complementary.
  function automatic code_info_t check_code(input logic [3:0] code);
    code_info_t info;
    info.legal  = code[3] & (code[2] == ~code[1]);
    info.status = {code[1] ^ code[0], code[0]};
    return info;
  endfunction

endpackage

// File: rtl/modulo_status_decoder_code_check.sv
// Combinational legality check and status recovery for one code word.
module status_code_check
  import modulo_status_decoder_pkg::*;
(
  input  logic [3:0] stdig_in,
  output logic       legal,
  output logic [1:0] decoded
);

  code_info_t info;

  assign info    = check_code(stdig_in);
  assign legal   = info.legal;
  assign decoded = info.status;

endmodule

// File: rtl/modulo_status_decoder.sv
// Receive-side status decoder: checks code words, filters glitches through a
// confirm/lock FSM and keeps a saturating count of illegal words.
module modulo_status_decoder
  import modulo_status_decoder_pkg::*;
#(
  parameter int STABLE_N = 3,
  parameter int LOSS_N   = 2,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sample_en,
  input  logic [3:0]       stdig_in,
  input  logic             err_clr,
  output logic [1:0]       std_out,
  output logic             std_valid,
  output logic             std_changed,
  output logic             code_err,
  output logic [ERR_W-1:0] err_count
);

  localparam logic [4:0]       STABLE_L = 5'(STABLE_N);
  localparam logic [4:0]       LOSS_L   = 5'(LOSS_N);
  localparam logic [ERR_W-1:0] ERR_ONE  = {{(ERR_W-1){1'b0}}, 1'b1};

  state_t           state, state_n;
  logic [1:0]       cand, cand_n;
  logic [3:0]       run, run_n;
  logic [3:0]       loss, loss_n;
  logic [1:0]       out_n;
  logic             valid_n, changed_n, code_err_n;
  logic [ERR_W-1:0] err_n;
  logic             legal;
  logic [1:0]       decoded;
  logic [4:0]       run_inc, loss_inc;
  logic             do_commit, lose;
  logic [1:0]       commit_val;

  status_code_check u_check (
    .stdig_in (stdig_in),
    .legal    (legal),
    .decoded  (decoded)
  );

  assign run_inc  = {1'b0, run} + 5'd1;
  assign loss_inc = {1'b0, loss} + 5'd1;

  always_comb begin
    state_n    = state;
    cand_n     = cand;
    run_n      = run;
    loss_n     = loss;
    out_n      = std_out;
    valid_n    = std_valid;
    changed_n  = 1'b0;
    code_err_n = 1'b0;
    err_n      = err_count;
    do_commit  = 1'b0;
    commit_val = cand;
    lose       = 1'b0;

    if (sample_en) begin
      if (!legal) begin
        code_err_n = 1'b1;
        if (err_count != '1) err_n = err_count + ERR_ONE;
      end

      unique case (state)
        NOLOCK: begin
          if (legal) begin
            cand_n = decoded;
            run_n  = 4'd1;
            if (STABLE_N == 1) begin
              do_commit  = 1'b1;
              commit_val = decoded;
            end else begin
              state_n = CONFIRM;
            end
          end
        end
        CONFIRM: begin
          if (legal) begin
            loss_n = 4'd0;
            if (decoded == cand) begin
              if (run_inc >= STABLE_L) begin
                do_commit  = 1'b1;
                commit_val = cand;
              end else begin
                run_n = run_inc[3:0];
              end
            end else begin
              cand_n = decoded;
              run_n  = 4'd1;
              if (STABLE_N == 1) begin
                do_commit  = 1'b1;
                commit_val = decoded;
              end
            end
          end else begin
            run_n = 4'd0;
            if (!std_valid) state_n = NOLOCK;
            else            lose    = 1'b1;
          end
        end
        LOCKED: begin
          if (legal) begin
            loss_n = 4'd0;
            if (decoded != std_out) begin
              cand_n = decoded;
              run_n  = 4'd1;
              if (STABLE_N == 1) begin
                do_commit  = 1'b1;
                commit_val = decoded;
              end else begin
                state_n = CONFIRM;
              end
            end
          end else begin
            lose = 1'b1;
          end
        end
        default: state_n = NOLOCK;
      endcase

      // Losing lock keeps the last std_out so consumers see a stale but sane value.
      if (lose) begin
        if (loss_inc >= LOSS_L) begin
          valid_n = 1'b0;
          loss_n  = 4'd0;
          state_n = NOLOCK;
        end else begin
          loss_n  = loss_inc[3:0];
          state_n = LOCKED;
        end
      end

      if (do_commit) begin
        out_n     = commit_val;
        valid_n   = 1'b1;
        changed_n = !std_valid || (commit_val != std_out);
        run_n     = 4'd0;
        loss_n    = 4'd0;
        state_n   = LOCKED;
      end
    end

    if (err_clr) err_n = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= NOLOCK;
      cand        <= 2'b00;
      run         <= 4'd0;
      loss        <= 4'd0;
      std_out     <= 2'b00;
      std_valid   <= 1'b0;
      std_changed <= 1'b0;
      code_err    <= 1'b0;
      err_count   <= '0;
    end else begin
      state       <= state_n;
      cand        <= cand_n;
      run         <= run_n;
      loss        <= loss_n;
      std_out     <= out_n;
      std_valid   <= valid_n;
      std_changed <= changed_n;
      code_err    <= code_err_n;
      err_count   <= err_n;
    end
  end

endmodule

// File: doc/modulo_status_decoder.md
Name: modulo_status_decoder

Overview:
- Receive side of the 4-bit status-digit code. Recovers the 2-bit status from code words, checks each word for legality, and filters glitches before the status is published.
- Code map: status 00->4'b1100, 01->4'b1011, 10->4'b1010, 11->4'b1101. In general, code = {1, ~(s1^s0), s1^s0, s0}.
- Sits between the digit/status bus and the control logic that consumes the current status.

Parameters:
- STABLE_N, 3: number of consecutive identical legal samples required before std_out changes; legal range 1..15.
- LOSS_N, 2: number of consecutive illegal samples while locked that drop std_valid; legal range 1..15.
- ERR_W, 8: width of the saturating error counter.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- sample_en  input  1  when 1, stdig_in is sampled at this edge.
- stdig_in  input  4  received status-digit code word.
- err_clr  input  1  synchronous clear of err_count.
- std_out  output  2  confirmed status.
- std_valid  output  1  std_out holds a confirmed status.
- std_changed  output  1  one-cycle pulse when std_out is loaded with a new or first value.
- code_err  output  1  one-cycle pulse for each illegal sampled word.
- err_count  output  ERR_W  saturating count of illegal words.

Behaviour:
- Reset (async, rst_n=0): std_out=00, std_valid=0, std_changed=0, code_err=0, err_count=0, state=NOLOCK, cand=00, run counters=0. Reset mid-sequence discards any partial confirmation.
- Legality is combinational on stdig_in: legal iff stdig_in[3]==1 and stdig_in[2]==~stdig_in[1].
- Decode: d0=stdig_in[0], d1=stdig_in[1]^stdig_in[0].
- With sample_en=0: no state, counter or output change, except that the pulses return to 0 and err_clr still acts.
- Illegal sample: code_err=1 for the next cycle; err_count increments, saturating at all-ones.
- err_clr: sets err_count=0. It takes priority over a same-cycle increment (the increment is lost, but code_err still pulses).
- State NOLOCK:
  - legal sample -> cand=decoded, run=1.
  - If STABLE_N==1, commit immediately; otherwise go to CONFIRM.
  - illegal sample -> stay in NOLOCK.
- State CONFIRM:
  - legal sample equal to cand -> run++. When run reaches STABLE_N, commit.
  - legal sample different from cand -> cand=new value, run=1.
  - illegal sample -> run=0. Return to NOLOCK if std_valid==0, otherwise to LOCKED with the loss counter incremented.
- Commit: std_out=cand and std_valid=1 at that edge. std_changed=1 for one cycle if std_valid was 0 or cand differs from the old std_out. Then go to LOCKED.
- Latency: std_out is visible on the cycle after the edge that samples the STABLE_N-th matching word.
- State LOCKED:
  - legal sample equal to std_out -> loss=0, stay.
  - legal sample different from std_out -> loss=0, cand=new, run=1, go to CONFIRM (commit directly if STABLE_N==1). std_out and std_valid hold during re-confirmation.
  - illegal sample -> loss++. When loss reaches LOSS_N: std_valid=0, go to NOLOCK, loss=0. std_out keeps its last value.
- Loss counting is also active in CONFIRM when std_valid==1; a legal sample clears loss.
- Run and loss counters are 4 bits wide and never wrap: run is bounded by STABLE_N and loss by LOSS_N.

Decomposition:
- Shared package holds:
  - state enum (NOLOCK, CONFIRM, LOCKED);
  - the four code constants (CODE_S00=4'hC, CODE_S01=4'hB, CODE_S10=4'hA, CODE_S11=4'hD);
  - a legality/decode function shared with the encoder-side checker.
- One natural sub-module: status_code_check, a combinational block (stdig_in -> legal, decoded[1:0]). Everything else stays in the top module.

Test Plan:
1. Reset then stdig_in=4'hB, sample_en=1 for 3 cycles -> std_out=01, std_valid=1 and std_changed pulse one cycle after the 3rd sample; no pulse before that.
2. Locked on 01, then apply 4'hA,4'hA,4'hD,4'hD,4'hD -> std_out stays 01 until the 3rd 4'hD; then std_out=11 with one std_changed pulse; std_valid stays 1 throughout.
3. Locked on 11, then apply 4'h5 then 4'hD -> one code_err pulse, err_count=1, std_valid stays 1. Then apply 4'h5,4'h0 -> std_valid=0 after the 2nd, err_count=3, std_out still 11.
4. Force 260 illegal samples with ERR_W=8 -> err_count saturates at 255. err_clr in the same cycle as an illegal sample -> err_count=0 and code_err=1.
5. Two 4'hC samples, then sample_en=0 for 5 cycles, then one 4'hC -> commit on the 3rd sampled word; idle cycles change nothing.
6. Drop rst_n asynchronously mid-CONFIRM (between clock edges) -> all outputs are 0 immediately; after release, a full STABLE_N samples are needed to lock.
